// File: rtl/fifo_pair_packer_if.sv
// fifo_pair_packer_if
//   Bundles the FIFO dequeue port and the packed valid/ready output of
//   fifo_pair_packer.
//   master : the packer side (pops the FIFO, drives the packed beat)
//   slave  : the environment side (FIFO head, flush, downstream ready)
//   Signals:
//     fifo_valid    FIFO non-empty, fifo_data is the head (fall-through)
//     fifo_data     FIFO head word
//     fifo_deque_en pop the FIFO head at this rising edge
//     flush         force emission of a held lone word
//     pk_valid      packed beat valid
//     pk_ready      consumer accepts the beat
//     pk_data       packed beat, first-popped word in the low lane
//     pk_mask       lane valid, 2'b11 pair / 2'b01 half beat
//     partial_cnt   half beats emitted since reset (wraps)
interface fifo_pair_packer_if #(
  parameter int DWIDTH = 64
);
  logic                  fifo_valid;
  logic [DWIDTH-1:0]     fifo_data;
  logic                  fifo_deque_en;
  logic                  flush;
  logic                  pk_valid;
  logic                  pk_ready;
  logic [2*DWIDTH-1:0]   pk_data;
  logic [1:0]            pk_mask;
  logic [31:0]           partial_cnt;

  modport master (
    input  fifo_valid, fifo_data, flush, pk_ready,
    output fifo_deque_en, pk_valid, pk_data, pk_mask, partial_cnt
  );

  modport slave (
    output fifo_valid, fifo_data, flush, pk_ready,
    input  fifo_deque_en, pk_valid, pk_data, pk_mask, partial_cnt
  );
endinterface

// File: rtl/fifo_pair_packer.sv
// fifo_pair_packer
//   Pops words from a first-word fall-through FIFO and packs consecutive
//   pairs into one 2*DWIDTH beat on a valid/ready output. A lone word is
//   emitted as a half beat (mask 2'b01) after TIMEOUT idle cycles or when
//   flush is seen; TIMEOUT=0 leaves only the flush path.
//   Ports:
//     clk  single clock, rising edge
//     rst  synchronous active-high reset
//     bus  fifo_pair_packer_if.master (FIFO dequeue side + packed output)
module fifo_pair_packer #(
  parameter int DWIDTH  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  fifo_pair_packer_if.master bus
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic {IDLE, HALF} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DWIDTH-1:0]     r_lo_p0;
  logic [TW-1:0]         r_timer;
  logic                  r_vld_p1;
  logic [2*DWIDTH-1:0]   r_pk_data_p1;
  logic [1:0]            r_pk_mask_p1;
  logic [31:0]           r_partial_cnt;

  logic                  w_slot_free;
  logic                  w_pop;
  logic                  w_expire;
  logic                  w_capture;
  logic                  w_load_pair;
  logic                  w_load_half;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == TMAX) ? v : v + TW'(1);
  endfunction

  assign w_slot_free = !r_vld_p1 || bus.pk_ready;
  // A pop in IDLE only fills lo, so it never waits on the output slot.
  assign w_pop       = !rst && bus.fifo_valid && (r_state == IDLE || w_slot_free);
  assign w_expire    = (TIMEOUT != 0) && (r_timer == TMAX);

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_load_pair = 1'b0;
    w_load_half = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_capture   = 1'b1;
          w_state_nxt = HALF;
        end
      end
      HALF: begin
        // A completing word beats the timeout/flush in the same cycle.
        if (w_pop) begin
          w_load_pair = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_slot_free && (bus.flush || w_expire)) begin
          w_load_half = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Stage p0: lone-word holding register and its age timer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo_p0 <= '0;
      r_timer <= '0;
    end else if (w_capture) begin
      r_lo_p0 <= bus.fifo_data;
      r_timer <= '0;
    end else if (r_state == HALF && !w_load_pair && !w_load_half) begin
      r_timer <= sat_inc(r_timer);
    end
  end

  // Stage p1: output beat register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1      <= 1'b0;
      r_pk_data_p1  <= '0;
      r_pk_mask_p1  <= 2'b00;
      r_partial_cnt <= '0;
    end else if (w_load_pair) begin
      r_vld_p1      <= 1'b1;
      r_pk_data_p1  <= {bus.fifo_data, r_lo_p0};
      r_pk_mask_p1  <= 2'b11;
    end else if (w_load_half) begin
      r_vld_p1      <= 1'b1;
      r_pk_data_p1  <= {{DWIDTH{1'b0}}, r_lo_p0};
      r_pk_mask_p1  <= 2'b01;
      r_partial_cnt <= r_partial_cnt + 32'd1;
    end else if (bus.pk_ready) begin
      r_vld_p1      <= 1'b0;
    end
  end

  assign bus.fifo_deque_en = w_pop;
  assign bus.pk_valid      = r_vld_p1;
  assign bus.pk_data       = r_pk_data_p1;
  assign bus.pk_mask       = r_pk_mask_p1;
  assign bus.partial_cnt   = r_partial_cnt;

endmodule

// File: doc/fifo_pair_packer.md
# fifo_pair_packer

Downstream consumer of the dual-enqueue FIFO: pops 64-bit words from the FIFO's dequeue port and packs consecutive pairs into one 2×DWIDTH beat on a valid/ready output. A lone word is emitted as a half beat on a timeout or an explicit flush, so traffic never stalls in the packer. It sits between the FIFO output and the wide datapath that consumes it.

## Interface
- DWIDTH, 64, width of one FIFO word
- TIMEOUT, 16, cycles a lone word waits before it is emitted as a half beat; 0 disables the timeout (flush only)
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- fifo_valid  in  1  FIFO non-empty; fifo_data is the head word, first-word fall-through
- fifo_data  in  DWIDTH  FIFO head word
- fifo_deque_en  out  1  pop the FIFO head at this rising edge
- flush  in  1  force emission of a held lone word
- pk_valid  out  1  output beat valid
- pk_ready  in  1  consumer accepts the beat this cycle
- pk_data  out  2*DWIDTH  packed beat; first-popped word in [DWIDTH-1:0]
- pk_mask  out  2  lane valid: 2'b11 for a full pair, 2'b01 for a half beat
- partial_cnt  out  32  number of half beats emitted since reset, wraps

## Operation
- Internal state:
  - lo register (DWIDTH)
  - FSM {IDLE, HALF}
  - timer, width $clog2(TIMEOUT+1), minimum 1
  - output register (pk_data, pk_mask, pk_valid)
- Output slot is free when !pk_valid || pk_ready.
- fifo_deque_en = !rst && fifo_valid && (state==IDLE || slot_free). It is combinational and depends on pk_ready.
- IDLE:
  - on pop: lo <= fifo_data, timer <= 0, go to HALF.
  - flush has no effect.
- HALF, priority order:
  - Pop: pk_data <= {fifo_data, lo}, pk_mask <= 2'b11, pk_valid <= 1, go to IDLE.
  - Else, if slot free and (flush, or TIMEOUT!=0 and timer==TIMEOUT): pk_data <= {0, lo}, pk_mask <= 2'b01, pk_valid <= 1, partial_cnt++, go to IDLE.
  - Else: timer increments, saturating at TIMEOUT.
- flush is a level sampled each cycle. A flush seen while the slot is blocked is not remembered; it must be held until taken.
- Output register: pk_valid clears on pk_ready when no new beat is loaded in the same cycle. Load and drain in the same cycle are legal and sustain one beat per cycle.
- While pk_valid && !pk_ready, pk_data and pk_mask stay stable.
- A pop in IDLE never needs the slot, so a word may be captured into lo while a previous beat is stalled.

## Timing
- Reset values: state IDLE, lo 0, timer 0, pk_valid 0, pk_data 0, pk_mask 0, partial_cnt 0, fifo_deque_en 0.
- Reset applied mid-operation discards lo and any undelivered beat.
- Pair latency:
  - second word popped at edge k -> pk_valid high after edge k.
  - with pk_ready held high, throughput is one pair beat every 2 pop cycles.
  - sustained rate is 1 word per cycle when fifo_valid stays high.
- Timeout:
  - lone word captured at edge k (timer=0).
  - timer reaches TIMEOUT after edge k+TIMEOUT.
  - half beat loads at edge k+TIMEOUT+1 if the slot is free and no pop occurs there.
- A word arriving in the same cycle as timer==TIMEOUT completes the pair; no half beat is produced.
- Stalled output in HALF:
  - the pop is blocked and the timer saturates.
  - the half beat or pair loads at the first edge where pk_ready is high.
- No combinational path from fifo_data to any output.

## Test plan
- Pair packing:
  - stimulus: DWIDTH=64, FIFO holds 114514 then 7, pk_ready=1.
  - response: two pops on consecutive cycles; one beat pk_data={64'd7, 64'd114514}, pk_mask=2'b11; partial_cnt=0.
- Timeout:
  - stimulus: TIMEOUT=4, single word 0xAA popped at edge k, no further words.
  - response: pk_valid rises after edge k+5 with pk_data[63:0]=0xAA, upper lane 0, pk_mask=2'b01; partial_cnt=1.
- Race at timeout:
  - stimulus: same as the timeout case, but a second word 0xBB is presented so it pops at edge k+5.
  - response: one beat {0xBB, 0xAA}, mask 2'b11; partial_cnt stays 0.
- Backpressure:
  - stimulus: stream 6 words with pk_ready=0 for 10 cycles after the first beat, then pk_ready=1.
  - response: fifo_deque_en low while HALF is blocked; beat 1 held stable; 3 beats total in order, no word lost or duplicated.
- Flush:
  - stimulus: TIMEOUT=0, lone word, flush pulsed 3 cycles later.
  - response: half beat emitted after that edge; without flush, the word is held indefinitely.
- Reset mid-stream:
  - stimulus: assert rst for 1 cycle while in HALF with a stalled beat.
  - response: all outputs at their reset values after that edge; subsequent pairs pack correctly.
